// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extension unit: mode encodings and the
// combinational extension function, also usable directly by decode logic.
package imm_ext_pkg;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t MODE_ZERO   = 2'd0;
    localparam imm_mode_t MODE_SIGN   = 2'd1;
    localparam imm_mode_t MODE_UPPER  = 2'd2;
    localparam imm_mode_t MODE_BRANCH = 2'd3;

    // Widest immediate/result the helper can serve; callers pad to this width.
    localparam int unsigned IMM_MAX_W = 64;

    typedef logic [IMM_MAX_W-1:0] imm_word_t;

    localparam imm_word_t IMM_ONES = {IMM_MAX_W{1'b1}};
    localparam imm_word_t IMM_ONE  = {{(IMM_MAX_W-1){1'b0}}, 1'b1};

    // in_w/out_w are expected to be elaboration constants at the call site.
    function automatic imm_word_t imm_extend(
        input imm_word_t   imm,
        input imm_mode_t   mode,
        input int unsigned in_w,
        input int unsigned out_w
    );
        imm_word_t in_mask;
        imm_word_t out_mask;
        imm_word_t raw;
        imm_word_t sext;
        imm_word_t res;
        logic      sign;

        in_mask  = ~(IMM_ONES << in_w);
        out_mask = ~(IMM_ONES << out_w);
        raw      = imm & in_mask;
        sign     = |(raw & (IMM_ONE << (in_w - 32'd1)));
        if (sign) begin
            sext = raw | ~in_mask;
        end else begin
            sext = raw;
        end

        case (mode)
            MODE_ZERO:   res = raw;
            MODE_SIGN:   res = sext;
            MODE_UPPER:  res = raw << (out_w - in_w);
            MODE_BRANCH: res = sext << 2'd2;
            default:     res = raw;
        endcase

        return res & out_mask;
    endfunction

endpackage : imm_ext_pkg

// File: rtl/imm_ext_skid.sv
// Valid/ready storage stage for extended results. Define IMM_EXTEND_SKID_EN
// for a two-entry skid buffer with registered in_ready; otherwise one register.
module imm_ext_skid #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

`ifdef IMM_EXTEND_SKID_EN

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         ready_q, ready_d;
    logic         in_fire_s;
    logic         out_fire_s;

    // Next-state for the output slot, the overflow slot and registered ready.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        in_fire_s    = in_valid && ready_q;
        out_fire_s   = main_valid_q && out_ready;

        if (!main_valid_q || out_fire_s) begin
            // Output slot frees up: the older skid entry always moves first.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = in_fire_s;
                if (in_fire_s) begin
                    skid_d = in_data;
                end else begin
                    skid_d = skid_q;
                end
            end else begin
                main_valid_d = in_fire_s;
                if (in_fire_s) begin
                    main_d = in_data;
                end else begin
                    main_d = main_q;
                end
            end
        end else begin
            if (in_fire_s) begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end else begin
                skid_d       = skid_q;
                skid_valid_d = skid_valid_q;
            end
        end

        ready_d = !(main_valid_d && skid_valid_d);
    end

    // Storage registers; reset empties both entries immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_q       <= {W{1'b0}};
            skid_q       <= {W{1'b0}};
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

`else

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         in_ready_s;

    // Single output register: reload whenever it is empty or being drained.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        in_ready_s = !valid_q || out_ready;

        if (in_ready_s) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Output register; reset empties it immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= {W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_q;
    assign out_data  = data_q;

`endif

endmodule : imm_ext_skid

// File: rtl/imm_extend_unit.sv
// Immediate extension unit: extends in_imm per in_mode and registers the result
// behind a valid/ready stage. Build option: IMM_EXTEND_SKID_EN (see imm_ext_skid).
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  imm_mode_t        in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    if ((OUT_W < IN_W + 2) || (OUT_W > IMM_MAX_W)) begin : g_bad_cfg
        $error("imm_extend_unit: OUT_W must satisfy IN_W+2 <= OUT_W <= IMM_MAX_W");
    end

    imm_word_t        imm_pad_s;
    imm_word_t        ext_full_s;
    logic [OUT_W-1:0] ext_s;

    // Extension is purely combinational; it is captured only on input transfer.
    always_comb begin
        imm_pad_s  = {{(IMM_MAX_W-IN_W){1'b0}}, in_imm};
        ext_full_s = imm_extend(imm_pad_s, in_mode, IN_W, OUT_W);
        ext_s      = ext_full_s[OUT_W-1:0];
    end

    if (OUT_W < IMM_MAX_W) begin : g_pad_unused
        logic ext_unused_s;
        assign ext_unused_s = ^ext_full_s[IMM_MAX_W-1:OUT_W];
    end

    imm_ext_skid #(
        .W (OUT_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (ext_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule : imm_extend_unit

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit (IN_W=16, OUT_W=32) with a result
// scoreboard; works with and without IMM_EXTEND_SKID_EN.
module tb_imm_extend_unit;

    localparam logic [1:0] M_ZERO   = 2'd0;
    localparam logic [1:0] M_SIGN   = 2'd1;
    localparam logic [1:0] M_UPPER  = 2'd2;
    localparam logic [1:0] M_BRANCH = 2'd3;

`ifdef IMM_EXTEND_SKID_EN
    localparam int BP_ACCEPT = 2;
`else
    localparam int BP_ACCEPT = 1;
`endif

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    logic [31:0] drv_exp;
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_pass;
    int          bp_idx;
    logic [15:0] bp_vals[3];

    imm_extend_unit #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        case (mode)
            M_ZERO:  return {16'h0000, imm};
            M_SIGN:  return {{16{imm[15]}}, imm};
            M_UPPER: return {imm, 16'h0000};
            default: return {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    task automatic drive(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        drv_exp  = exp;
    endtask

    // One isolated transfer; result must be present the very next cycle.
    task automatic single(input string tag, input logic [15:0] imm, input logic [1:0] mode,
                          input logic [31:0] exp);
        @(posedge clock); #1;
        drive(imm, mode, exp);
        @(negedge clock);
        check({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0) break;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    // Scoreboard: compare outgoing results, then record newly accepted ones.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 32'd1);
                end else begin
                    check("sb_data", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(drv_exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_imm    = 16'h0000;
        in_mode   = M_ZERO;
        out_ready = 1'b1;
        drv_exp   = 32'd0;
        bp_vals   = '{16'h000A, 16'h000B, 16'h000C};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        drive(16'h8001, M_ZERO, 32'h0000_8001);
        @(negedge clock);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("first_edge_lat1", {31'd0, out_valid}, 32'd1);

        single("sign",    16'h8001, M_SIGN,   32'hFFFF_8001);
        single("upper",   16'h1234, M_UPPER,  32'h1234_0000);
        single("br_neg",  16'hFFFF, M_BRANCH, 32'hFFFF_FFFC);
        single("br_pos",  16'h7FFF, M_BRANCH, 32'h0001_FFFC);
        @(negedge clock);
        check("idle_after_single", {31'd0, out_valid}, 32'd0);

        // Streaming: eight back-to-back transfers with no stall.
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            drive(16'(i), M_SIGN, model(16'(i), M_SIGN));
            @(negedge clock);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) check("stream_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("stream_last_valid", {31'd0, out_valid}, 32'd1);
        drain("stream_drain");

        // Mixed modes through the model, including sign-bit boundaries.
        for (int i = 0; i < 12; i++) begin
            logic [15:0] r;
            logic [1:0]  m;
            r = 16'($urandom);
            m = 2'(i % 4);
            if (i == 4) r = 16'h8000;
            if (i == 5) r = 16'h7FFF;
            @(posedge clock); #1;
            drive(r, m, model(r, m));
            @(negedge clock);
        end
        drain("mixed_drain");

        // Backpressure: downstream stalled for four cycles.
        out_ready = 1'b0;
        bp_idx    = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            if (bp_idx < 3) drive(bp_vals[bp_idx], M_ZERO, model(bp_vals[bp_idx], M_ZERO));
            else in_valid = 1'b0;
            @(negedge clock);
            if (c >= 1) begin
                check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                check("bp_hold_data", out_data, 32'h0000_000A);
            end
            if (c == 3) check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            if (in_valid && in_ready) bp_idx++;
        end
        check("bp_accepted", bp_idx, BP_ACCEPT);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            if (bp_idx < 3) drive(bp_vals[bp_idx], M_ZERO, model(bp_vals[bp_idx], M_ZERO));
            else in_valid = 1'b0;
            @(negedge clock);
            if (in_valid && in_ready) bp_idx++;
            if (bp_idx == 3) break;
        end
        check("bp_all_accepted", bp_idx, 32'd3);
        drain("bp_drain");

        // Simultaneous in/out transfer with one entry held.
        @(posedge clock); #1;
        drive(16'h0011, M_SIGN, model(16'h0011, M_SIGN));
        @(negedge clock);
        @(posedge clock); #1;
        drive(16'h8022, M_SIGN, model(16'h8022, M_SIGN));
        @(negedge clock);
        check("simul_out_valid", {31'd0, out_valid}, 32'd1);
        check("simul_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("simul_no_bubble", {31'd0, out_valid}, 32'd1);
        @(negedge clock);
        check("simul_empty", {31'd0, out_valid}, 32'd0);

        // Reset while results are stored.
        out_ready = 1'b0;
        @(posedge clock); #1;
        drive(16'h0101, M_ZERO, model(16'h0101, M_ZERO));
        @(negedge clock);
        @(posedge clock); #1;
        drive(16'h0202, M_ZERO, model(16'h0202, M_ZERO));
        @(negedge clock);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("mid_stored_valid", {31'd0, out_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_async", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("post_rst_no_emit", {31'd0, out_valid}, 32'd0);
            check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        single("post_rst", 16'h0005, M_ZERO, 32'h0000_0005);
        drain("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imm_extend_unit

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 Parameter: IN_W, default 16, immediate input width in bits.
REQ-002 Parameter: OUT_W, default 32, extended output width in bits; legal only when OUT_W >= IN_W+2.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  upstream immediate present.
REQ-006 Port: in_ready  output  1  unit can accept this cycle.
REQ-007 Port: in_imm  input  IN_W  raw immediate field.
REQ-008 Port: in_mode  input  2  extension mode; encodings in REQ-013.
REQ-009 Port: out_valid  output  1  extended result present.
REQ-010 Port: out_ready  input  1  downstream consumes this cycle.
REQ-011 Port: out_data  output  OUT_W  extended result.

Function
REQ-012 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-013 Mode ZERO (0): zero-extend to OUT_W. Mode SIGN (1): replicate bit IN_W-1 to OUT_W. Mode UPPER (2): immediate placed in bits [OUT_W-1 : OUT_W-IN_W], low bits zero. Mode BRANCH (3): sign-extend, shift left 2, keep low OUT_W bits.
REQ-014 Extension is computed from in_imm/in_mode at input transfer and registered; in_imm/in_mode are not sampled at any other time.
REQ-015 Latency: result appears on out_data with out_valid high in the cycle after input transfer; no combinational path from in_imm to out_data.
REQ-016 out_data and out_valid hold stable while out_valid && !out_ready.
REQ-017 Results leave in acceptance order; none lost or duplicated.
REQ-018 Simultaneous input and output transfer in one cycle is legal; occupancy unchanged, new result replaces the consumed one in order.
REQ-019 in_ready is low only when storage is full and out_ready cannot free it per the selected configuration (REQ-024/025).
REQ-020 out_data is don't-care while out_valid is low; bench checks out_data only with out_valid.

Reset
REQ-021 reset high: all entries invalid immediately (asynchronous); out_valid=0, out_data=0, in_ready=1 from the next cycle after release.
REQ-022 Reset mid-operation discards every stored result; none is emitted after release.
REQ-023 First input transfer is allowed in the first clock edge after reset deasserts.

Configuration
REQ-024 Macro IMM_EXTEND_SKID_EN defined: two-entry skid buffer; in_ready is a register output (no combinational path from out_ready); in_ready=0 only when both entries full; full throughput sustained with out_ready held high.
REQ-025 Macro IMM_EXTEND_SKID_EN undefined: single output register; in_ready = !out_valid || out_ready (combinational); full throughput still sustained.
REQ-026 Functional results, ordering and latency (REQ-013..018) are identical in both configurations.

Structure
REQ-027 Package imm_ext_pkg holds the 2-bit mode constants MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_BRANCH and the width type for in_mode.
REQ-028 Extension arithmetic is a combinational function in imm_ext_pkg, reusable by decode logic.
REQ-029 Storage/handshake is sub-module imm_ext_skid (parametrised data width OUT_W), containing the IMM_EXTEND_SKID_EN selection.

Verification (IN_W=16, OUT_W=32)
REQ-030 Modes: in_imm=0x8001 ZERO -> 0x00008001; SIGN -> 0xFFFF8001; UPPER 0x1234 -> 0x12340000; BRANCH 0xFFFF -> 0xFFFFFFFC; BRANCH 0x7FFF -> 0x0001FFFC; each one cycle after transfer.
REQ-031 Streaming: in_valid high 8 cycles, out_ready high, in_imm 0..7 SIGN -> out_valid continuous from cycle 1, outputs 0..7 in order, in_ready never low.
REQ-032 Backpressure: out_ready low 4 cycles while feeding 0xA, 0xB, 0xC -> skid build: in_ready low after 2 accepted, out_data holds 0x0000000A stable; on out_ready high outputs 0xA, 0xB then 0xC; non-skid build: in_ready low after 1.
REQ-033 Simultaneous: occupancy 1, in and out transfer same cycle -> occupancy stays 1, next out_data is new value, no bubble.
REQ-034 Reset mid-stream: assert reset with 2 results stored -> out_valid 0 immediately, no stored value emitted after release, next input 0x0005 ZERO -> 0x00000005.
